// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a single shared ALU.
// Optional ALU_ARB_INVALID_BYPASS_EN: requests with inp_valid==00 are answered with err=1 and never issued.
module alu_req_arbiter #(
    parameter int WIDTH    = 8,
    parameter int CMD_BITS = 4,
    parameter int LAT      = 1,
    parameter int MUL_LAT  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*WIDTH-1:0]    req_opa,
    input  logic [2*WIDTH-1:0]    req_opb,
    input  logic [2*CMD_BITS-1:0] req_cmd,
    input  logic [1:0]            req_mode,
    input  logic [1:0]            req_cin,
    input  logic [3:0]            req_inp_valid,
    output logic [WIDTH-1:0]      alu_opa,
    output logic [WIDTH-1:0]      alu_opb,
    output logic [CMD_BITS-1:0]   alu_cmd,
    output logic                  alu_cin,
    output logic                  alu_ce,
    output logic                  alu_mode,
    output logic [1:0]            alu_inp_valid,
    input  logic [WIDTH:0]        alu_res,
    input  logic                  alu_oflow,
    input  logic                  alu_cout,
    input  logic                  alu_e,
    input  logic                  alu_g,
    input  logic                  alu_l,
    input  logic                  alu_err,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [WIDTH:0]        rsp_res,
    output logic [5:0]            rsp_flags
);

    localparam int MAX_L = (LAT > MUL_LAT) ? LAT : MUL_LAT;
    localparam int CNT_W = $clog2(MAX_L + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state;
    logic                 last_grant;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     lat_l;
    logic [WIDTH-1:0]     l_opa;
    logic [WIDTH-1:0]     l_opb;
    logic [CMD_BITS-1:0]  l_cmd;
    logic                 l_mode;
    logic                 l_cin;
    logic [1:0]           l_iv;
    logic                 l_id;

    logic                 grant_idx;
    logic                 take;
    logic [WIDTH-1:0]     sel_opa;
    logic [WIDTH-1:0]     sel_opb;
    logic [CMD_BITS-1:0]  sel_cmd;
    logic [1:0]           sel_iv;
    logic                 sel_mul;

    // A grant is taken from plain IDLE, or in the same edge as the response handshake.
    always_comb begin
        grant_idx = 1'b0;
        if (req_valid == 2'b11) grant_idx = ~last_grant;
        else                    grant_idx = req_valid[1];
        take = (|req_valid) &&
               (((state == IDLE) && (req_ready == 2'b00)) || ((state == RESP) && rsp_ready));
        sel_opa = grant_idx ? req_opa[2*WIDTH-1:WIDTH] : req_opa[WIDTH-1:0];
        sel_opb = grant_idx ? req_opb[2*WIDTH-1:WIDTH] : req_opb[WIDTH-1:0];
        sel_cmd = grant_idx ? req_cmd[2*CMD_BITS-1:CMD_BITS] : req_cmd[CMD_BITS-1:0];
        sel_iv  = grant_idx ? req_inp_valid[3:2] : req_inp_valid[1:0];
        sel_mul = req_mode[grant_idx] &&
                  ((sel_cmd == CMD_BITS'(9)) || (sel_cmd == CMD_BITS'(10)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            cnt           <= '0;
            lat_l         <= '0;
            l_opa         <= '0;
            l_opb         <= '0;
            l_cmd         <= '0;
            l_mode        <= 1'b0;
            l_cin         <= 1'b0;
            l_iv          <= 2'b00;
            l_id          <= 1'b0;
            req_ready     <= 2'b00;
            alu_opa       <= '0;
            alu_opb       <= '0;
            alu_cmd       <= '0;
            alu_cin       <= 1'b0;
            alu_ce        <= 1'b0;
            alu_mode      <= 1'b0;
            alu_inp_valid <= 2'b00;
            rsp_valid     <= 1'b0;
            rsp_id        <= 1'b0;
            rsp_res       <= '0;
            rsp_flags     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_ready != 2'b00) begin
                        req_ready <= 2'b00;
`ifdef ALU_ARB_INVALID_BYPASS_EN
                        if (l_iv == 2'b00) begin
                            rsp_valid <= 1'b1;
                            rsp_id    <= l_id;
                            rsp_res   <= '0;
                            rsp_flags <= 6'b000001;
                            state     <= RESP;
                        end else
`endif
                        begin
                            alu_opa       <= l_opa;
                            alu_opb       <= l_opb;
                            alu_cmd       <= l_cmd;
                            alu_mode      <= l_mode;
                            alu_cin       <= l_cin;
                            alu_inp_valid <= l_iv;
                            alu_ce        <= 1'b1;
                            state         <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= lat_l;
                    state <= WAIT;
                end
                WAIT: begin
                    // cnt==1 marks the edge that closes cycle issue+L, where the ALU result is valid.
                    if (cnt == CNT_W'(1)) begin
                        rsp_res       <= alu_res;
                        rsp_flags     <= {alu_oflow, alu_cout, alu_e, alu_g, alu_l, alu_err};
                        rsp_id        <= l_id;
                        rsp_valid     <= 1'b1;
                        alu_ce        <= 1'b0;
                        alu_inp_valid <= 2'b00;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (take) begin
                req_ready  <= grant_idx ? 2'b10 : 2'b01;
                last_grant <= grant_idx;
                l_id       <= grant_idx;
                l_opa      <= sel_opa;
                l_opb      <= sel_opb;
                l_cmd      <= sel_cmd;
                l_mode     <= req_mode[grant_idx];
                l_cin      <= req_cin[grant_idx];
                l_iv       <= sel_iv;
                lat_l      <= sel_mul ? CNT_W'(MUL_LAT) : CNT_W'(LAT);
            end
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed vectors, a small ALU model, scoreboard queues checked by monitors.
module tb_alu_req_arbiter;
    localparam int WIDTH    = 8;
    localparam int CMD_BITS = 4;
    localparam int LAT      = 1;
    localparam int MUL_LAT  = 2;

    logic                  clk;
    logic                  rst;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [2*WIDTH-1:0]    req_opa;
    logic [2*WIDTH-1:0]    req_opb;
    logic [2*CMD_BITS-1:0] req_cmd;
    logic [1:0]            req_mode;
    logic [1:0]            req_cin;
    logic [3:0]            req_inp_valid;
    logic [WIDTH-1:0]      alu_opa;
    logic [WIDTH-1:0]      alu_opb;
    logic [CMD_BITS-1:0]   alu_cmd;
    logic                  alu_cin;
    logic                  alu_ce;
    logic                  alu_mode;
    logic [1:0]            alu_inp_valid;
    logic [WIDTH:0]        alu_res;
    logic                  alu_oflow;
    logic                  alu_cout;
    logic                  alu_e;
    logic                  alu_g;
    logic                  alu_l;
    logic                  alu_err;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [WIDTH:0]        rsp_res;
    logic [5:0]            rsp_flags;

    alu_req_arbiter #(.WIDTH(WIDTH), .CMD_BITS(CMD_BITS), .LAT(LAT), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opa(req_opa), .req_opb(req_opb), .req_cmd(req_cmd),
        .req_mode(req_mode), .req_cin(req_cin), .req_inp_valid(req_inp_valid),
        .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cmd(alu_cmd),
        .alu_cin(alu_cin), .alu_ce(alu_ce), .alu_mode(alu_mode), .alu_inp_valid(alu_inp_valid),
        .alu_res(alu_res), .alu_oflow(alu_oflow), .alu_cout(alu_cout),
        .alu_e(alu_e), .alu_g(alu_g), .alu_l(alu_l), .alu_err(alu_err),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_res(rsp_res), .rsp_flags(rsp_flags)
    );

    typedef struct packed {
        logic [7:0] opa;
        logic [7:0] opb;
        logic [3:0] cmd;
        logic       mode;
        logic       cin;
        logic [1:0] iv;
        logic       mul;
        logic [8:0] res;
        logic [5:0] flags;
    } vec_t;

    vec_t        vt [0:10];
    int          cur_vec [2];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          hs_cyc = 0;
    logic [19:0] exp_q[$];     // {latency, id, res, flags}
    int          acc_q[$];
    logic [27:0] exp_ce_q[$];  // {ce length, opa, opb, cmd, mode, cin, inp_valid}

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ALU stand-in: outputs are only meaningful once CE has been high for latency+1 sampled cycles.
    int ce_run = 0;
    always @(negedge clk) begin
        logic [8:0] r;
        logic [5:0] f;
        int         need;
        int         p;
        if (rst || !alu_ce) ce_run = 0;
        else ce_run++;
        need = (alu_mode && (alu_cmd == 4'd9 || alu_cmd == 4'd10)) ? MUL_LAT : LAT;
        r = 9'h000;
        f = 6'b000000;
        p = 0;
        if (alu_inp_valid != 2'b11) f = 6'b000001;
        else if (alu_mode) begin
            case (alu_cmd)
                4'd0: begin r = {1'b0, alu_opa} + {1'b0, alu_opb}; f[4] = r[8]; end
                4'd1: begin r = {1'b0, alu_opa} - {1'b0, alu_opb}; f[5] = (alu_opa < alu_opb); end
                4'd2: begin r = {1'b0, alu_opa} + {1'b0, alu_opb} + {8'h00, alu_cin}; f[4] = r[8]; end
                4'd8: begin f[3] = (alu_opa == alu_opb); f[2] = (alu_opa > alu_opb); f[1] = (alu_opa < alu_opb); end
                4'd9: begin p = int'(alu_opa) * int'(alu_opb); r = p[8:0]; end
                4'd10: begin p = (int'(alu_opa) * 2) * int'(alu_opb); r = p[8:0]; end
                default: f = 6'b000001;
            endcase
        end else begin
            case (alu_cmd)
                4'd0: r = {1'b0, alu_opa & alu_opb};
                4'd1: r = {1'b0, alu_opa | alu_opb};
                default: r = {1'b0, alu_opa ^ alu_opb};
            endcase
        end
        if (alu_ce && ce_run > need) begin
            alu_res = r;
            {alu_oflow, alu_cout, alu_e, alu_g, alu_l, alu_err} = f;
        end else begin
            alu_res = 9'h155;
            {alu_oflow, alu_cout, alu_e, alu_g, alu_l, alu_err} = 6'b111111;
        end
    end

    // CE monitor: each CE burst must match a queued issue (length, bus contents, hold).
    int          run = 0;
    logic [23:0] first_bus;
    logic        bus_stable;
    always @(negedge clk) begin
        logic [27:0] e;
        if (rst) run = 0;
        else if (alu_ce) begin
            if (run == 0) begin
                first_bus  = {alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_inp_valid};
                bus_stable = 1'b1;
            end else if ({alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_inp_valid} != first_bus) begin
                bus_stable = 1'b0;
            end
            run++;
        end else if (run > 0) begin
            if (exp_ce_q.size() == 0) check("ce_unexpected", run, 0);
            else begin
                e = exp_ce_q.pop_front();
                check("ce_len", run, {28'h0, e[27:24]});
                check("alu_bus", first_bus, e[23:0]);
                check("alu_hold", bus_stable, 1);
                check("inp_valid_clear", alu_inp_valid, 0);
            end
            run = 0;
        end
    end

    // Response monitor: pops the scoreboard on every handshake.
    logic        prev_v = 1'b0;
    logic [15:0] rsp_hold;
    logic        rsp_stable;
    int          rise_cyc = 0;
    always @(negedge clk) begin
        logic [19:0] e;
        int          a;
        if (rst) prev_v = 1'b0;
        else begin
            if (rsp_valid && !prev_v) begin
                rsp_hold   = {rsp_id, rsp_res, rsp_flags};
                rise_cyc   = cyc;
                rsp_stable = 1'b1;
            end else if (rsp_valid && ({rsp_id, rsp_res, rsp_flags} != rsp_hold)) begin
                rsp_stable = 1'b0;
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check("rsp_data", {rsp_id, rsp_res, rsp_flags}, {16'h0, e[15:0]});
                    check("rsp_latency", rise_cyc - a, {28'h0, e[19:16]});
                    check("rsp_hold", rsp_stable, 1);
                end
                hs_cyc = cyc;
            end
            prev_v = rsp_valid && !rsp_ready;
        end
    end

    // driver tasks
    task automatic post(input int id, input int v);
        cur_vec[id]                        = v;
        req_valid[id]                      = 1'b1;
        req_opa[id*WIDTH +: WIDTH]         = vt[v].opa;
        req_opb[id*WIDTH +: WIDTH]         = vt[v].opb;
        req_cmd[id*CMD_BITS +: CMD_BITS]   = vt[v].cmd;
        req_mode[id]                       = vt[v].mode;
        req_cin[id]                        = vt[v].cin;
        req_inp_valid[id*2 +: 2]           = vt[v].iv;
    endtask

    task automatic push_exp(input int g, input int acyc);
        vec_t v;
        logic byp;
        int   lat;
        v   = vt[cur_vec[g]];
        byp = 1'b0;
`ifdef ALU_ARB_INVALID_BYPASS_EN
        byp = (v.iv == 2'b00);
`endif
        lat = byp ? 1 : ((v.mul ? MUL_LAT : LAT) + 2);
        exp_q.push_back({4'(lat), 1'(g), v.res, v.flags});
        acc_q.push_back(acyc);
        if (!byp)
            exp_ce_q.push_back({4'((v.mul ? MUL_LAT : LAT) + 1), v.opa, v.opb, v.cmd, v.mode, v.cin, v.iv});
    endtask

    task automatic wait_grant(input int exp_g, input bit do_push, output int acyc);
        int n;
        n    = 0;
        acyc = -1;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == 2'b00 && n < 50);
        if (req_ready == 2'b00) check("grant_timeout", 0, 1);
        else begin
            acyc = cyc;
            check("grant_id", req_ready, (exp_g == 1) ? 2 : 1);
            if (do_push) push_exp(exp_g, acyc);
        end
    endtask

    task automatic after_grant(input int g, input int next_v);
        @(posedge clk);
        #1;
        if (next_v < 0) req_valid[g] = 1'b0;
        else post(g, next_v);
        @(negedge clk);
        check("ready_pulse", req_ready, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", (exp_q.size() == 0) && !rsp_valid, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_check(input string name);
        check(name, {req_ready, alu_opa, alu_opb, alu_cmd, alu_cin, alu_ce, alu_mode, alu_inp_valid}, 0);
        check(name, {rsp_valid, rsp_id, rsp_res, rsp_flags}, 0);
    endtask

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int acyc;
        int n;
        //          opa    opb    cmd   m     cin   iv     mul   res     flags
        vt[0]  = '{8'h05, 8'h03, 4'd0, 1'b1, 1'b0, 2'b11, 1'b0, 9'h008, 6'b000000};
        vt[1]  = '{8'hFF, 8'h02, 4'd0, 1'b1, 1'b0, 2'b11, 1'b0, 9'h101, 6'b010000};
        vt[2]  = '{8'h10, 8'h20, 4'd1, 1'b1, 1'b0, 2'b11, 1'b0, 9'h1F0, 6'b100000};
        vt[3]  = '{8'h07, 8'h07, 4'd8, 1'b1, 1'b0, 2'b11, 1'b0, 9'h000, 6'b001000};
        vt[4]  = '{8'h09, 8'h04, 4'd8, 1'b1, 1'b0, 2'b11, 1'b0, 9'h000, 6'b000100};
        vt[5]  = '{8'h02, 8'h03, 4'd9, 1'b1, 1'b0, 2'b11, 1'b1, 9'h006, 6'b000000};
        vt[6]  = '{8'h0C, 8'h0A, 4'd0, 1'b0, 1'b0, 2'b11, 1'b0, 9'h008, 6'b000000};
        vt[7]  = '{8'h0C, 8'h0A, 4'd9, 1'b0, 1'b0, 2'b11, 1'b0, 9'h006, 6'b000000};
        vt[8]  = '{8'h03, 8'h05, 4'd10, 1'b1, 1'b0, 2'b11, 1'b1, 9'h01E, 6'b000000};
        vt[9]  = '{8'h44, 8'h55, 4'd0, 1'b1, 1'b0, 2'b00, 1'b0, 9'h000, 6'b000001};
        vt[10] = '{8'h01, 8'h01, 4'd2, 1'b1, 1'b1, 2'b11, 1'b0, 9'h003, 6'b000000};

        rst           = 1'b1;
        req_valid     = 2'b00;
        req_opa       = '0;
        req_opb       = '0;
        req_cmd       = '0;
        req_mode      = 2'b00;
        req_cin       = 2'b00;
        req_inp_valid = 4'b0000;
        rsp_ready     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_check("reset_outputs");
        @(posedge clk);
        #1 rst = 1'b0;

        // single ADD from requester 0
        post(0, 0);
        wait_grant(0, 1'b1, acyc);
        after_grant(0, -1);
        drain();

        // both requesters continuously valid after a fresh reset: 0,1,0,1
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        reset_check("reset2_outputs");
        @(posedge clk);
        #1;
        post(0, 1);
        post(1, 2);
        wait_grant(0, 1'b1, acyc);
        after_grant(0, 3);
        wait_grant(1, 1'b1, acyc);
        after_grant(1, 4);
        wait_grant(0, 1'b1, acyc);
        after_grant(0, -1);
        wait_grant(1, 1'b1, acyc);
        after_grant(1, -1);
        drain();

        // multiply and non-multiply latencies, single requesters
        @(posedge clk);
        #1 post(1, 5);
        wait_grant(1, 1'b1, acyc);
        after_grant(1, -1);
        drain();
        @(posedge clk);
        #1 post(0, 6);
        wait_grant(0, 1'b1, acyc);
        after_grant(0, -1);
        drain();
        @(posedge clk);
        #1 post(1, 8);
        wait_grant(1, 1'b1, acyc);
        after_grant(1, -1);
        drain();
        @(posedge clk);
        #1 post(0, 7);
        wait_grant(0, 1'b1, acyc);
        after_grant(0, -1);
        drain();

        // response backpressure with both requesters pending (last grant was 0)
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        post(0, 10);
        post(1, 0);
        wait_grant(1, 1'b1, acyc);
        after_grant(1, 3);
        n = 0;
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("rsp_wait", rsp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            check("ready_during_resp", req_ready, 0);
            check("valid_during_stall", rsp_valid, 1);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_grant(0, 1'b1, acyc);
        check("grant_after_hs", acyc, hs_cyc + 1);
        after_grant(0, -1);
        wait_grant(1, 1'b1, acyc);
        after_grant(1, -1);
        drain();

        // reset while a multiply from requester 0 sits in WAIT
        @(posedge clk);
        #1 post(0, 5);
        wait_grant(0, 1'b0, acyc);
        after_grant(0, -1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        reset_check("reset_in_wait");
        @(posedge clk);
        #1;
        post(0, 6);
        post(1, 7);
        wait_grant(0, 1'b1, acyc);
        after_grant(0, -1);
        wait_grant(1, 1'b1, acyc);
        after_grant(1, -1);
        drain();

        // inp_valid == 00
        @(posedge clk);
        #1 post(0, 9);
        wait_grant(0, 1'b1, acyc);
        after_grant(0, -1);
        drain();

        repeat (5) @(negedge clk);
        check("leftover_rsp", exp_q.size(), 0);
        check("leftover_ce", exp_ce_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
